// File: rtl/mem_bus_ctrl_if.sv
// CPU-side bus of the memory-map controller: request qualifiers,
// write data, registered read data and the ack/err completion pair.
interface mem_bus_ctrl_if #(
    parameter int ADDR_W = 19
) ();
    logic [ADDR_W-1:0] CPUaddr;
    logic [15:0]       CPUwrite;
    logic [15:0]       CPUread;
    logic              we;
    logic              re;
    logic              be;
    logic              bios;
    logic              ack;
    logic              err;

    // CPU drives the request and waits for ack.
    modport master (
        output CPUaddr, CPUwrite, we, re, be, bios,
        input  CPUread, ack, err
    );

    // Controller receives the request and reports completion.
    modport slave (
        input  CPUaddr, CPUwrite, we, re, be, bios,
        output CPUread, ack, err
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Memory-map bus controller: decodes CPU byte addresses into BIOS, UART,
// HEX and RAM regions, steers byte lanes, inserts per-region wait states
// and finishes each access with a one-cycle ack (err on misaligned or
// conflicting requests). All outputs come straight from registers.
module mem_bus_ctrl #(
    parameter int          ADDR_W    = 19,
    parameter int          DATA_W    = 16,
    parameter logic [15:0] BIOS_TOP  = 16'h0800,
    parameter logic [15:0] HEX_BASE  = 16'hff80,
    parameter logic [15:0] UART_BASE = 16'hff90,
    parameter int          RAM_WAIT  = 1,
    parameter int          UART_WAIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_ctrl_if.slave     cpu,
    output logic [ADDR_W-2:0] RAMaddr,
    output logic [15:0]       RAMwrite,
    input  logic [15:0]       RAMread,
    output logic [1:0]        RAMbe,
    output logic              RAMwe,
    input  logic [15:0]       BIOSread,
    output logic [2:0]        UARTaddr,
    output logic [7:0]        UARTwrite,
    input  logic [7:0]        UARTread,
    output logic              UARTwe,
    output logic              UARTre,
    output logic              UARTce,
    output logic              HEXwe,
    output logic [15:0]       HEXdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
    typedef enum logic [1:0] {REG_RAM = 2'd0, REG_BIOS = 2'd1, REG_UART = 2'd2, REG_HEX = 2'd3} region_t;

    localparam logic [ADDR_W-1:0] BIOS_TOP_A  = ADDR_W'(BIOS_TOP);
    localparam logic [ADDR_W-1:0] HEX_BASE_A  = ADDR_W'(HEX_BASE);
    localparam logic [ADDR_W-1:0] UART_BASE_A = ADDR_W'(UART_BASE);

    // Region priority: BIOS overlay (reads only), UART, HEX, then RAM.
    function automatic region_t region_f(input logic [ADDR_W-1:0] a, input logic bs, input logic rd);
        if (rd && bs && (a < BIOS_TOP_A))  return REG_BIOS;
        else if (a >= UART_BASE_A)         return REG_UART;
        else if (a >= HEX_BASE_A)          return REG_HEX;
        else                               return REG_RAM;
    endfunction

    function automatic logic [2:0] wait_f(input region_t r);
        case (r)
            REG_RAM, REG_BIOS: return 3'(RAM_WAIT);
            REG_UART:          return 3'(UART_WAIT);
            default:           return 3'd0;
        endcase
    endfunction

    // Byte writes travel on the lane selected by the address LSB.
    function automatic logic [15:0] wr_steer_f(input logic [15:0] d, input logic b, input logic odd);
        if (b && odd)  return {8'h00, d[7:0]};
        else if (b)    return {d[7:0], 8'h00};
        else           return d;
    endfunction

    function automatic logic [1:0] wr_lanes_f(input logic b, input logic odd);
        if (b && odd)  return 2'b01;
        else if (b)    return 2'b10;
        else           return 2'b11;
    endfunction

    // Byte reads return the addressed lane in the low byte.
    function automatic logic [15:0] rd_lane_f(input logic [15:0] src, input logic b, input logic odd);
        if (b && odd)  return {8'h00, src[7:0]};
        else if (b)    return {8'h00, src[15:8]};
        else           return src;
    endfunction

    state_t            state_r, next_state_s;
    region_t           region_r, in_region_s, sel_region_s;
    logic [2:0]        cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [15:0]       wdata_r, ramwrite_r, cpuread_r, hexdata_r, rdata_s;
    logic              be_r, we_r, re_r;
    logic              ack_r, err_r, ramwe_r, uartwe_r, uartre_r, uartce_r, hexwe_r;
    logic [1:0]        rambe_r;
    logic              accept_s, capture_s, in_err_s, go_access_s;
    logic              sel_we_s, sel_re_s, sel_be_s, sel_odd_s;

    assign in_region_s = region_f(cpu.CPUaddr, cpu.bios, cpu.re && !cpu.we);
    assign in_err_s    = (cpu.we && cpu.re) || (!cpu.be && cpu.CPUaddr[0]);

    // Next state plus accept/capture qualifiers for the datapath.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (cpu.we || cpu.re) begin
                    accept_s     = 1'b1;
                    next_state_s = in_err_s ? RESP : ACCESS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_r == 3'd0) begin
                    capture_s    = 1'b1;
                    next_state_s = RESP;
                end else begin
                    next_state_s = ACCESS;
                end
            end
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Strobes for the coming cycle use the incoming request on acceptance,
    // otherwise the latched one.
    always_comb begin
        go_access_s  = (next_state_s == ACCESS);
        sel_region_s = accept_s ? in_region_s : region_r;
        sel_we_s     = accept_s ? cpu.we : we_r;
        sel_re_s     = accept_s ? cpu.re : re_r;
        sel_be_s     = accept_s ? cpu.be : be_r;
        sel_odd_s    = accept_s ? cpu.CPUaddr[0] : addr_r[0];
    end

    // Read-data source selection for the capture edge.
    always_comb begin
        rdata_s = 16'h0000;
        case (region_r)
            REG_BIOS: rdata_s = rd_lane_f(BIOSread, be_r, addr_r[0]);
            REG_UART: rdata_s = {8'h00, UARTread};
            REG_HEX:  rdata_s = hexdata_r;
            default:  rdata_s = rd_lane_f(RAMread, be_r, addr_r[0]);
        endcase
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= IDLE;
        else       state_r <= next_state_s;
    end

    // Request latch and wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r      <= 3'd0;
            addr_r     <= '0;
            wdata_r    <= 16'h0000;
            ramwrite_r <= 16'h0000;
            region_r   <= REG_RAM;
            be_r       <= 1'b0;
            we_r       <= 1'b0;
            re_r       <= 1'b0;
        end else if (accept_s) begin
            cnt_r      <= wait_f(in_region_s);
            addr_r     <= cpu.CPUaddr;
            wdata_r    <= cpu.CPUwrite;
            ramwrite_r <= wr_steer_f(cpu.CPUwrite, cpu.be, cpu.CPUaddr[0]);
            region_r   <= in_region_s;
            be_r       <= cpu.be;
            we_r       <= cpu.we;
            re_r       <= cpu.re;
        end else if (state_r == ACCESS && cnt_r != 3'd0) begin
            cnt_r <= cnt_r - 3'd1;
        end
    end

    // Read capture, error result, HEX register load and completion flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpuread_r <= 16'h0000;
            hexdata_r <= 16'h0000;
            ack_r     <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            ack_r <= (next_state_s == RESP);
            err_r <= (next_state_s == RESP) && accept_s && in_err_s;
            if (accept_s && in_err_s) begin
                cpuread_r <= 16'h0000;
            end else if (capture_s && re_r) begin
                cpuread_r <= rdata_s;
            end
            if (capture_s && we_r && region_r == REG_HEX) begin
                hexdata_r <= be_r ? {8'h00, wdata_r[7:0]} : wdata_r;
            end
        end
    end

    // Downstream strobes and lane enables, high only during ACCESS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ramwe_r  <= 1'b0;
            rambe_r  <= 2'b00;
            uartce_r <= 1'b0;
            uartwe_r <= 1'b0;
            uartre_r <= 1'b0;
            hexwe_r  <= 1'b0;
        end else begin
            ramwe_r  <= go_access_s && sel_region_s == REG_RAM && sel_we_s;
            uartce_r <= go_access_s && sel_region_s == REG_UART;
            uartwe_r <= go_access_s && sel_region_s == REG_UART && sel_we_s;
            uartre_r <= go_access_s && sel_region_s == REG_UART && sel_re_s;
            hexwe_r  <= go_access_s && sel_region_s == REG_HEX && sel_we_s;
            if (go_access_s && (sel_region_s == REG_RAM || sel_region_s == REG_BIOS)) begin
                rambe_r <= sel_we_s ? wr_lanes_f(sel_be_s, sel_odd_s) : 2'b11;
            end else begin
                rambe_r <= 2'b00;
            end
        end
    end

    assign cpu.CPUread = cpuread_r;
    assign cpu.ack     = ack_r;
    assign cpu.err     = err_r;
    assign RAMaddr     = addr_r[ADDR_W-1:1];
    assign RAMwrite    = ramwrite_r;
    assign RAMbe       = rambe_r;
    assign RAMwe       = ramwe_r;
    assign UARTaddr    = addr_r[2:0];
    assign UARTwrite   = wdata_r[7:0];
    assign UARTwe      = uartwe_r;
    assign UARTre      = uartre_r;
    assign UARTce      = uartce_r;
    assign HEXwe       = hexwe_r;
    assign HEXdata     = hexdata_r;
endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Registered, parametrised memory-map bus controller between the CPU and the RAM, BIOS ROM, 7-segment HEX register and UART 16450.
- Decodes the CPU byte address into regions.
- Steers byte lanes for RAM and BIOS.
- Inserts per-region wait states, then completes each access with a one-cycle ack.
- Flags misaligned word accesses through err.
- Holds the HEX display value in an internal register that the CPU can read back.

Parameters:
ADDR_W, 19, CPU byte-address width; RAMaddr is ADDR_W-1 bits wide.
DATA_W, 16, data bus width; must be 16 (two byte lanes).
BIOS_TOP, 16'h0800, BIOS overlay region is addresses below this, active only while bios=1.
HEX_BASE, 16'hff80, first HEX register address.
UART_BASE, 16'hff90, first UART address; the UART region runs to the top of the address space.
RAM_WAIT, 1, extra ACCESS cycles for RAM and BIOS; range 0-7.
UART_WAIT, 2, extra ACCESS cycles for the UART; range 0-7.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
CPUaddr  in  ADDR_W  byte address
CPUwrite  in  16  write data; byte writes use bits [7:0]
CPUread  out  16  registered read data
we  in  1  write request
re  in  1  read request
be  in  1  1 = byte access, 0 = word access
bios  in  1  BIOS overlay enable
ack  out  1  one-cycle completion pulse
err  out  1  error flag, valid only while ack=1
RAMaddr  out  ADDR_W-1  word address, equal to CPUaddr[ADDR_W-1:1]
RAMwrite  out  16  lane-steered write data
RAMread  in  16  RAM read data
RAMbe  out  2  lane enables, [1]=high byte, [0]=low byte
RAMwe  out  1  RAM write strobe
BIOSread  in  16  BIOS ROM word
UARTaddr  out  3  CPUaddr[2:0]
UARTwrite  out  8  CPUwrite[7:0]
UARTread  in  8  UART read data
UARTwe  out  1  UART write strobe
UARTre  out  1  UART read strobe
UARTce  out  1  UART chip enable
HEXwe  out  1  one-cycle pulse when the HEX register is written
HEXdata  out  16  HEX register contents

Behaviour:
- Reset (asynchronous, active-high):
  - state goes to IDLE and the wait counter clears.
  - CPUread, ack, err, every strobe, RAMbe and HEXdata go to 0.
  - Asserting reset mid-access drops all strobes immediately; the access is abandoned and no ack is issued.
- Address, write data and the be/bios/we/re qualifiers are latched at request acceptance. All downstream address/data outputs are driven from the latched values.
- Region decode, on the latched address, in priority order:
  1. BIOS, for reads only: addr < BIOS_TOP and bios=1.
  2. UART: addr >= UART_BASE.
  3. HEX: addr >= HEX_BASE.
  4. RAM: everything else. Writes below BIOS_TOP go to RAM (shadow write).
- State machine IDLE -> ACCESS -> RESP -> IDLE:
  - IDLE: if we or re is high at a clock edge, latch the request and load cnt with the region's wait count (HEX uses 0).
  - IDLE, error shortcut: if both we and re are high, or be=0 with addr[0]=1 (misaligned word access), go directly to RESP with err=1. No strobes are issued and CPUread is set to 0.
  - ACCESS: strobes are held steady for cnt+1 cycles, decrementing cnt each cycle. At the edge where cnt==0, read data is captured into CPUread and the state moves to RESP.
  - RESP: ack=1 for one cycle with all strobes low, then return to IDLE.
  - Latency: ack is high W+2 cycles after the accepting edge, where W is the region wait. The CPU holds its request until ack; the request is re-sampled only in IDLE.
- Strobes, active only in ACCESS:
  - RAMwe for RAM writes.
  - UARTce for every UART access, plus UARTwe or UARTre according to direction.
  - HEXwe for one cycle on a HEX write. HEXdata loads the full latched write data on that cycle, or the low byte zero-extended when be=1.
- Byte lanes, write path:
  - be=0: RAMbe=11, RAMwrite=CPUwrite.
  - be=1, odd address: RAMbe=01, RAMwrite={8'h00, CPUwrite[7:0]}.
  - be=1, even address: RAMbe=10, RAMwrite={CPUwrite[7:0], 8'h00}.
  - RAMbe=11 on reads.
- Byte lanes, read path:
  - be=1, odd address: {8'h00, src[7:0]}.
  - be=1, even address: {8'h00, src[15:8]}.
  - Otherwise the full word.
  - src is RAMread or BIOSread according to region.
  - UART reads always return {8'h00, UARTread}.
  - HEX reads return HEXdata.
- CPUread holds its value until the next capture.

Test Plan:
- Word write of 16'h1234 to 0x0100 with RAM_WAIT=1 -> RAMwe high exactly 2 cycles, RAMaddr=0x0080, RAMbe=11; ack high on the 3rd cycle after acceptance, err=0.
- Byte writes of CPUwrite=16'h00ab to 0x0101 and then 0x0100 -> RAMbe=01 with RAMwrite=16'h00ab, then RAMbe=10 with RAMwrite=16'hab00.
- Byte read from 0x0200 with bios=1, BIOSread=16'hbeef -> CPUread=16'h00be at ack. The same read with bios=0 returns the RAMread high byte instead.
- UART byte read from 0xff95 with UART_WAIT=2, UARTread=8'h5a -> UARTce/UARTre high for 3 cycles, UARTaddr=3'b101, CPUread=16'h005a.
- Word write of 16'hc0de to 0xff80, then read from 0xff80 -> HEXwe pulses once, HEXdata=16'hc0de, read returns 16'hc0de.
- Word read from 0x0003 -> no strobes, ack one cycle after acceptance, err=1, CPUread=0. Asserting reset during a UART ACCESS -> strobes low immediately and no ack.
